// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: per-unit completion FIFOs (ALU/LSU/BRU) feeding the single ROB/PRF
// writeback port. Fixed priority BRU > LSU > ALU with an aging override, a grant lock
// that holds the presented packet stable while the consumer stalls, stale-epoch
// dropping at each FIFO head, and a global flush.
module wb_arbiter_rr #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ROB_W      = 6,
    parameter int unsigned PHYS_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    // ALU completion port
    input  logic              alu_wb_valid,
    output logic              alu_wb_ready,
    input  logic [ROB_W-1:0]  alu_wb_rob_idx,
    input  logic [PHYS_W-1:0] alu_wb_prd_new,
    input  logic [31:0]       alu_wb_data,
    input  logic [1:0]        alu_wb_epoch,
    input  logic              alu_wb_uses_rd,
    // LSU completion port
    input  logic              lsu_wb_valid,
    output logic              lsu_wb_ready,
    input  logic [ROB_W-1:0]  lsu_wb_rob_idx,
    input  logic [PHYS_W-1:0] lsu_wb_prd_new,
    input  logic [31:0]       lsu_wb_data,
    input  logic [1:0]        lsu_wb_epoch,
    input  logic              lsu_wb_uses_rd,
    // BRU completion port
    input  logic              bru_wb_valid,
    output logic              bru_wb_ready,
    input  logic [ROB_W-1:0]  bru_wb_rob_idx,
    input  logic [PHYS_W-1:0] bru_wb_prd_new,
    input  logic [31:0]       bru_wb_data,
    input  logic [1:0]        bru_wb_epoch,
    input  logic              bru_wb_uses_rd,
    // Control
    input  logic [1:0]        cur_epoch,
    input  logic              flush,
    // Writeback port
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [1:0]        wb_src,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [PHYS_W-1:0] wb_prd_new,
    output logic [31:0]       wb_data,
    output logic [1:0]        wb_epoch,
    output logic              wb_uses_rd
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int          NSRC  = 3;

    // Source indices; a higher index means higher fixed priority.
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_BRU = 2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [2:0]       WAIT_MAX = 3'(STARVE_MAX);

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PHYS_W-1:0] prd_new;
        logic [31:0]       data;
        logic [1:0]        epoch;
        logic              uses_rd;
    } entry_t;

    // Storage and FIFO state
    entry_t           r_mem     [NSRC][DEPTH];
    logic [PTR_W-1:0] r_rptr    [NSRC];
    logic [PTR_W-1:0] r_wptr    [NSRC];
    logic [CNT_W-1:0] r_count   [NSRC];
    logic [2:0]       r_wait    [NSRC];
    logic             r_lock;
    logic [1:0]       r_lock_src;

    // Next-state
    logic [PTR_W-1:0] w_rptr_d  [NSRC];
    logic [PTR_W-1:0] w_wptr_d  [NSRC];
    logic [CNT_W-1:0] w_count_d [NSRC];
    logic [2:0]       w_wait_d  [NSRC];

    // Per-source combinational status
    entry_t           w_in_entry [NSRC];
    entry_t           w_head     [NSRC];
    logic [NSRC-1:0]  w_in_valid;
    logic [NSRC-1:0]  w_ready;
    logic [NSRC-1:0]  w_push;
    logic [NSRC-1:0]  w_pop;
    logic [NSRC-1:0]  w_elig;
    logic [NSRC-1:0]  w_stale;
    logic [NSRC-1:0]  w_granted;

    // Selection
    logic             w_sel_valid;
    logic [1:0]       w_sel;
    entry_t           w_sel_entry;
    logic             w_handshake;

    assign w_in_valid = {bru_wb_valid, lsu_wb_valid, alu_wb_valid};

    assign w_in_entry[SRC_ALU] = {alu_wb_rob_idx, alu_wb_prd_new, alu_wb_data,
                                  alu_wb_epoch, alu_wb_uses_rd};
    assign w_in_entry[SRC_LSU] = {lsu_wb_rob_idx, lsu_wb_prd_new, lsu_wb_data,
                                  lsu_wb_epoch, lsu_wb_uses_rd};
    assign w_in_entry[SRC_BRU] = {bru_wb_rob_idx, bru_wb_prd_new, bru_wb_data,
                                  bru_wb_epoch, bru_wb_uses_rd};

    assign alu_wb_ready = w_ready[SRC_ALU];
    assign lsu_wb_ready = w_ready[SRC_LSU];
    assign bru_wb_ready = w_ready[SRC_BRU];

    assign w_handshake = w_sel_valid && wb_ready;

    // Head decode: occupancy, epoch eligibility, push acceptance
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            w_head[s]  = r_mem[s][r_rptr[s]];
            w_elig[s]  = (r_count[s] != '0) && (w_head[s].epoch == cur_epoch);
            w_stale[s] = (r_count[s] != '0) && (w_head[s].epoch != cur_epoch);
            w_ready[s] = (r_count[s] != CNT_FULL) && !flush;
            w_push[s]  = w_in_valid[s] && w_ready[s];
        end
    end

    // Source selection: lock first, then aged heads, then plain priority
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = 2'd0;
        w_sel_entry = '0;
        if (!flush) begin
            if (r_lock) begin
                // A stale locked head yields no packet this cycle; it is dropped instead.
                for (int s = 0; s < NSRC; s++) begin
                    if (r_lock_src == 2'(s) && w_elig[s]) begin
                        w_sel_valid = 1'b1;
                        w_sel       = 2'(s);
                        w_sel_entry = w_head[s];
                    end
                end
            end else begin
                for (int s = NSRC - 1; s >= 0; s--) begin
                    if (!w_sel_valid && w_elig[s] && (r_wait[s] == WAIT_MAX)) begin
                        w_sel_valid = 1'b1;
                        w_sel       = 2'(s);
                        w_sel_entry = w_head[s];
                    end
                end
                for (int s = NSRC - 1; s >= 0; s--) begin
                    if (!w_sel_valid && w_elig[s]) begin
                        w_sel_valid = 1'b1;
                        w_sel       = 2'(s);
                        w_sel_entry = w_head[s];
                    end
                end
            end
        end
    end

    // Writeback bus drive; fields are all-zero whenever nothing is selected
    always_comb begin
        wb_valid = w_sel_valid;
        wb_src   = 2'd0;
        {wb_rob_idx, wb_prd_new, wb_data, wb_epoch, wb_uses_rd} = w_sel_entry;
        if (w_sel_valid) begin
            unique case (w_sel)
                2'd0:    wb_src = 2'd3;
                2'd1:    wb_src = 2'd2;
                2'd2:    wb_src = 2'd1;
                default: wb_src = 2'd0;
            endcase
        end
    end

    // FIFO pointer/count and aging next-state
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            w_granted[s] = w_handshake && (w_sel == 2'(s));
            // Granted heads are eligible, so grant and stale pops never coincide.
            w_pop[s]     = w_granted[s] || w_stale[s];

            w_rptr_d[s]  = w_pop[s]  ? r_rptr[s] + PTR_W'(1) : r_rptr[s];
            w_wptr_d[s]  = w_push[s] ? r_wptr[s] + PTR_W'(1) : r_wptr[s];

            unique case ({w_push[s], w_pop[s]})
                2'b10:   w_count_d[s] = r_count[s] + CNT_W'(1);
                2'b01:   w_count_d[s] = r_count[s] - CNT_W'(1);
                default: w_count_d[s] = r_count[s];
            endcase

            w_wait_d[s] = r_wait[s];
            if (w_granted[s] || (w_count_d[s] == '0)) begin
                w_wait_d[s] = 3'd0;
            end else if (w_elig[s] && wb_ready && (r_wait[s] < WAIT_MAX)) begin
                w_wait_d[s] = r_wait[s] + 3'd1;
            end

            if (flush) begin
                w_rptr_d[s]  = '0;
                w_wptr_d[s]  = '0;
                w_count_d[s] = '0;
                w_wait_d[s]  = 3'd0;
            end
        end
    end

    // FIFO control and aging registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSRC; s++) begin
                r_rptr[s]  <= '0;
                r_wptr[s]  <= '0;
                r_count[s] <= '0;
                r_wait[s]  <= 3'd0;
            end
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                r_rptr[s]  <= w_rptr_d[s];
                r_wptr[s]  <= w_wptr_d[s];
                r_count[s] <= w_count_d[s];
                r_wait[s]  <= w_wait_d[s];
            end
        end
    end

    // Grant lock: hold the presented source while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock     <= 1'b0;
            r_lock_src <= 2'd0;
        end else begin
            r_lock     <= w_sel_valid && !wb_ready;
            r_lock_src <= w_sel;
        end
    end

    // Entry storage; contents are qualified by the counts, so no reset is needed
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (w_push[s]) begin
                r_mem[s][r_wptr[s]] <= w_in_entry[s];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Self-checking bench for wb_arbiter_rr: directed vector table, hand-written stall and
// starvation sequences, and randomized traffic against a queue-based reference model.
module tb_wb_arbiter_rr;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    typedef struct packed {
        logic [5:0]  rob;
        logic [6:0]  prd;
        logic [31:0] data;
        logic [1:0]  ep;
        logic        rd;
    } ent_t;

    typedef struct packed {
        logic [2:0] v;      // {bru, lsu, alu}
        logic [5:0] rob;    // alu gets rob, lsu rob+1, bru rob+2
        logic [1:0] ep;
        logic [1:0] ce;
        logic       fl;
        logic       rdy;
        logic       e_valid;
        logic [1:0] e_src;
        logic [5:0] e_rob;
        logic [2:0] e_rdy;  // {bru, lsu, alu}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [2:0] in_v = '0;
    ent_t [2:0] in_e = '0;
    logic [1:0] cur_epoch = 2'd0;
    logic flush = 1'b0;
    logic wb_ready = 1'b1;

    logic alu_rdy, lsu_rdy, bru_rdy;
    logic wb_valid, wb_uses_rd;
    logic [1:0] wb_src, wb_epoch;
    logic [5:0] wb_rob_idx;
    logic [6:0] wb_prd_new;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model state: one queue per source (0=ALU, 1=LSU, 2=BRU)
    ent_t mq [3][$];
    int mwait [3];
    int mlock = -1;
    int msel = -1;
    logic [2:0] exp_rdy;

    // Last sampled DUT outputs
    logic act_valid;
    logic [1:0] act_src;
    logic [5:0] act_rob;
    logic [31:0] act_data;
    logic [2:0] act_rdy;

    always #5 clk = ~clk;

    wb_arbiter_rr #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .ROB_W      (6),
        .PHYS_W     (7)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_wb_valid   (in_v[0]),
        .alu_wb_ready   (alu_rdy),
        .alu_wb_rob_idx (in_e[0].rob),
        .alu_wb_prd_new (in_e[0].prd),
        .alu_wb_data    (in_e[0].data),
        .alu_wb_epoch   (in_e[0].ep),
        .alu_wb_uses_rd (in_e[0].rd),
        .lsu_wb_valid   (in_v[1]),
        .lsu_wb_ready   (lsu_rdy),
        .lsu_wb_rob_idx (in_e[1].rob),
        .lsu_wb_prd_new (in_e[1].prd),
        .lsu_wb_data    (in_e[1].data),
        .lsu_wb_epoch   (in_e[1].ep),
        .lsu_wb_uses_rd (in_e[1].rd),
        .bru_wb_valid   (in_v[2]),
        .bru_wb_ready   (bru_rdy),
        .bru_wb_rob_idx (in_e[2].rob),
        .bru_wb_prd_new (in_e[2].prd),
        .bru_wb_data    (in_e[2].data),
        .bru_wb_epoch   (in_e[2].ep),
        .bru_wb_uses_rd (in_e[2].rd),
        .cur_epoch      (cur_epoch),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_src         (wb_src),
        .wb_rob_idx     (wb_rob_idx),
        .wb_prd_new     (wb_prd_new),
        .wb_data        (wb_data),
        .wb_epoch       (wb_epoch),
        .wb_uses_rd     (wb_uses_rd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk_ent(input logic [5:0] rob, input logic [1:0] ep);
        ent_t e;
        e.rob  = rob;
        e.prd  = 7'(rob) + 7'd3;
        e.data = 32'hA500_0000 | 32'(rob);
        e.ep   = ep;
        e.rd   = rob[0];
        return e;
    endfunction

    function automatic bit m_elig(input int s);
        if (mq[s].size() == 0) return 1'b0;
        return mq[s][0].ep == cur_epoch;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) begin
            mq[s].delete();
            mwait[s] = 0;
        end
        mlock = -1;
    endfunction

    // Expected outputs for the current cycle
    function automatic void model_eval();
        msel = -1;
        for (int s = 0; s < 3; s++) exp_rdy[s] = (mq[s].size() < DEPTH) && !flush;
        if (!flush) begin
            if (mlock >= 0) begin
                if (m_elig(mlock)) msel = mlock;
            end else begin
                for (int s = 2; s >= 0; s--)
                    if (msel < 0 && m_elig(s) && mwait[s] == STARVE_MAX) msel = s;
                for (int s = 2; s >= 0; s--)
                    if (msel < 0 && m_elig(s)) msel = s;
            end
        end
    endfunction

    function automatic logic [63:0] exp_pack();
        ent_t e;
        logic [1:0] src;
        e = '0;
        src = 2'd0;
        if (msel >= 0) begin
            e = mq[msel][0];
            src = 2'(3 - msel);
        end
        return {10'd0, msel >= 0, src, e.rob, e.prd, e.data, e.ep, e.rd, exp_rdy};
    endfunction

    // Advance the model across the clock edge
    function automatic void model_update();
        bit granted;
        granted = (msel >= 0) && wb_ready;
        if (flush) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 3; s++) begin
            if (granted && msel == s) begin
                void'(mq[s].pop_front());
                mwait[s] = 0;
            end else if (mq[s].size() > 0 && mq[s][0].ep != cur_epoch) begin
                void'(mq[s].pop_front());
            end else if (mq[s].size() > 0 && wb_ready && mwait[s] < STARVE_MAX) begin
                mwait[s]++;
            end
            if (in_v[s] && exp_rdy[s]) mq[s].push_back(in_e[s]);
            if (mq[s].size() == 0) mwait[s] = 0;
        end
        mlock = (msel >= 0 && !wb_ready) ? msel : -1;
    endfunction

    // One clock: sample at negedge, compare with model, step past posedge
    task automatic tick(input string name);
        logic [63:0] act;
        @(negedge clk);
        model_eval();
        act = {10'd0, wb_valid, wb_src, wb_rob_idx, wb_prd_new, wb_data, wb_epoch,
               wb_uses_rd, bru_rdy, lsu_rdy, alu_rdy};
        act_valid = wb_valid;
        act_src   = wb_src;
        act_rob   = wb_rob_idx;
        act_data  = wb_data;
        act_rdy   = {bru_rdy, lsu_rdy, alu_rdy};
        check(name, act, exp_pack());
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_v = '0;
        flush = 1'b0;
        wb_ready = 1'b1;
        #2;
        model_reset();
        check("reset_state", {61'd0, wb_valid, wb_src, bru_rdy, lsu_rdy, alu_rdy},
              {61'd0, 1'b0, 2'd0, 3'b111});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_v = '0;
        flush = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick("drain");
    endtask

    task automatic rand_cycle(input bit allow_flush);
        for (int s = 0; s < 3; s++) begin
            in_v[s] = ($urandom_range(0, 99) < 60);
            in_e[s] = mk_ent(6'($urandom), ($urandom_range(0, 99) < 85) ? cur_epoch
                                                                       : 2'($urandom));
            in_e[s].data = $urandom;
        end
        if ($urandom_range(0, 99) < 3) cur_epoch = 2'($urandom);
        flush = allow_flush && ($urandom_range(0, 99) < 2);
        wb_ready = ($urandom_range(0, 99) < 65);
        tick("rand");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [16];
        int turn1, turn2;

        vecs[0]  = '{3'b101, 6'd10, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[1]  = '{3'b000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, 6'd12, 3'b111};
        vecs[2]  = '{3'b000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd3, 6'd10, 3'b111};
        vecs[3]  = '{3'b000, 6'd0,  2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[4]  = '{3'b001, 6'd20, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[5]  = '{3'b001, 6'd21, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[6]  = '{3'b000, 6'd0,  2'd1, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[7]  = '{3'b001, 6'd22, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[8]  = '{3'b000, 6'd0,  2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 2'd3, 6'd22, 3'b111};
        vecs[9]  = '{3'b000, 6'd0,  2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[10] = '{3'b111, 6'd30, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[11] = '{3'b111, 6'd40, 2'd2, 2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 6'd0,  3'b000};
        vecs[12] = '{3'b000, 6'd0,  2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[13] = '{3'b010, 6'd50, 2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};
        vecs[14] = '{3'b000, 6'd0,  2'd2, 2'd2, 1'b0, 1'b1, 1'b1, 2'd2, 6'd51, 3'b111};
        vecs[15] = '{3'b000, 6'd0,  2'd2, 2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  3'b111};

        #1;
        do_reset();

        // Directed vector table: priority, stale drop, flush
        for (int i = 0; i < 16; i++) begin
            in_v = vecs[i].v;
            for (int s = 0; s < 3; s++) in_e[s] = mk_ent(vecs[i].rob + 6'(s), vecs[i].ep);
            cur_epoch = vecs[i].ce;
            flush = vecs[i].fl;
            wb_ready = vecs[i].rdy;
            tick("vec_model");
            check($sformatf("vec%0d", i), {52'd0, act_valid, act_src, act_rob, act_rdy},
                  {52'd0, vecs[i].e_valid, vecs[i].e_src, vecs[i].e_rob, vecs[i].e_rdy});
        end
        flush = 1'b0;

        // Starvation: BRU streams while ALU holds two entries
        in_v = 3'b101;
        in_e[0] = mk_ent(6'd1, cur_epoch);
        in_e[2] = mk_ent(6'd40, cur_epoch);
        wb_ready = 1'b1;
        tick("starve");
        turn1 = 0;
        turn2 = 0;
        for (int k = 1; k <= 16; k++) begin
            in_v = (k == 1) ? 3'b101 : 3'b100;
            in_e[0] = mk_ent(6'd2, cur_epoch);
            in_e[2] = mk_ent(6'(40 + k), cur_epoch);
            tick("starve");
            if (act_valid && act_src == 2'd3) begin
                if (turn1 == 0) turn1 = k;
                else if (turn2 == 0) turn2 = k;
            end
            if (turn2 != 0) break;
        end
        check("starve_first_alu_turn", 64'(turn1), 64'd5);
        check("starve_second_alu_turn", 64'(turn2), 64'd10);
        drain();

        // Stall: LSU fills, locked packet holds, later BRU entry cannot preempt
        wb_ready = 1'b0;
        in_v = 3'b010;
        in_e[1] = mk_ent(6'd5, cur_epoch);
        in_e[1].data = 32'hDEAD_BEEF;
        tick("stall");
        in_e[1] = mk_ent(6'd6, cur_epoch);
        in_e[1].data = 32'h1234_5678;
        tick("stall");
        in_v = 3'b110;
        in_e[1] = mk_ent(6'd7, cur_epoch);
        in_e[2] = mk_ent(6'd9, cur_epoch);
        tick("stall");
        check("lsu_full_ready", 64'(act_rdy[1]), 64'd0);
        in_v = '0;
        for (int k = 0; k < 10; k++) begin
            tick("stall_hold_model");
            check("stall_hold", {23'd0, act_valid, act_src, act_rob, act_data},
                  {23'd0, 1'b1, 2'd2, 6'd5, 32'hDEAD_BEEF});
        end
        cur_epoch = cur_epoch + 2'd1;
        tick("stall_epoch");
        check("stall_epoch_drop", 64'(act_valid), 64'd0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) rand_cycle(1'b1);

        // Reset mid-traffic, then resume
        for (int i = 0; i < 6; i++) rand_cycle(1'b0);
        do_reset();
        for (int i = 0; i < 300; i++) rand_cycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Buffered, starvation-aware writeback arbiter that sits between the ALU/LSU/BRU completion ports and the single ROB/PRF writeback port. Each functional unit pushes completions into its own small FIFO. A fixed-priority scheduler with aging selects one head per cycle for the writeback bus. Stale-epoch entries are discarded at the FIFO head, and a flush empties all queues.

## Interface
Parameters:
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- STARVE_MAX, 4, cycles a valid head may be passed over before it is promoted (1..7)
- ROB_W, from defines.svh, ROB index width
- PHYS_W, from defines.svh, physical register index width

Ports (prefix p ∈ {alu, lsu, bru}; each line expands to three ports):
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- p_wb_valid  input  1  completion offered by the unit
- p_wb_ready  output  1  FIFO p accepts this cycle
- p_wb_rob_idx  input  ROB_W  ROB entry of the completion
- p_wb_prd_new  input  PHYS_W  destination physical register
- p_wb_data  input  32  result data
- p_wb_epoch  input  2  epoch tag of the completion
- p_wb_uses_rd  input  1  completion writes rd
- cur_epoch  input  2  current front-end epoch
- flush  input  1  discard all buffered state
- wb_valid  output  1  packet presented
- wb_ready  input  1  ROB/PRF accepts
- wb_src  output  2  source of packet: 1=BRU, 2=LSU, 3=ALU, 0 when idle
- wb_rob_idx, wb_prd_new, wb_data, wb_epoch, wb_uses_rd  output  ROB_W/PHYS_W/32/2/1  selected head fields, all zero when wb_valid=0

## Operation
- Per-source FIFO: read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
- p_wb_ready = (count_p != DEPTH) && !flush. The unit pushes on p_wb_valid && p_wb_ready.
- Stale drop: a head with epoch != cur_epoch is ineligible for arbitration and is popped in that cycle without grant. At most one pop per source per cycle.
- Eligible head: count_p ≠ 0 and epoch == cur_epoch.
- Aging counter wait_p, 3 bits: increments (saturating at STARVE_MAX) on each cycle head p is eligible but not granted while wb_ready=1. Clears to 0 on grant or when the FIFO empties.
- Selection, first match wins:
  - locked source (see below);
  - any eligible source with wait_p == STARVE_MAX, in order BRU > LSU > ALU;
  - any eligible source, in order BRU > LSU > ALU.
- Grant lock: if wb_valid && !wb_ready, the selection is registered. The same source is forced next cycle, and the presented fields stay bit-stable. The lock releases on handshake, flush, or when the locked head turns stale (head is dropped and wb_valid deasserts that cycle).
- Pop on wb_valid && wb_ready. A simultaneous push and pop on the same FIFO leaves count unchanged. A push into a full FIFO is impossible because ready is low.
- Flush: wb_valid=0 and all p_wb_ready=0 in the flush cycle. At the next edge all counts, pointers, wait counters and the lock clear. Pushes offered during flush are dropped.

## Timing
- Reset (async assert, sync release by clock edge): FIFOs empty, wait_p=0, lock=0, wb_valid=0, wb fields and wb_src=0, all p_wb_ready=1.
- Latency: a completion pushed at edge N can appear on wb_valid in cycle N+1 (after the edge). There is no input-to-output combinational path.
- wb_valid and the wb fields depend only on registered state plus cur_epoch, flush and wb_ready. They never depend on p_wb_valid.
- Throughput: one writeback per cycle sustained. Each source sustains one push per cycle while the FIFO is not full.
- Epoch change mid-stall: the locked head is dropped the first cycle its epoch mismatches cur_epoch.

## Test plan
- Reset with rst_n=0 mid-traffic → next cycle all FIFOs empty, wb_valid=0, alu/lsu/bru_wb_ready=1, wb_src=0.
- ALU and BRU each push one entry (epoch 0, cur_epoch 0) in the same cycle, wb_ready=1 → cycle+1: wb_src=1 (BRU); cycle+2: wb_src=3 (ALU); cycle+3: wb_valid=0.
- BRU pushes every cycle while ALU holds one entry, wb_ready=1, STARVE_MAX=4 → ALU is granted on the 5th output cycle, and its wait counter returns to 0.
- LSU fills DEPTH=2 with wb_ready=0 → lsu_wb_ready=0 after the second push. The presented packet rob_idx=5, data=0xDEADBEEF stays stable for 10 cycles. A later-arriving BRU entry does not preempt it.
- Queue ALU entries with epoch 1 while cur_epoch=2 → entries are popped without wb_valid and alu count reaches 0 within 2 cycles.
- Assert flush with all three FIFOs holding entries and concurrent pushes → wb_valid=0 that cycle, all counts 0 the next cycle, and no dropped entry ever appears on the writeback bus.
